// File: rtl/compare_sched.sv
// Round-robin scheduler that streams 256-bit hashes from N heavy-hash cores into one comparator.
// Define CMP_SCHED_STATS_EN to build the hashes_routed completion counter; otherwise it reads as 0.
module compare_sched #(
    parameter int N_CORES        = 4,
    parameter int WORDS_PER_HASH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [N_CORES-1:0]    req,
    output logic [N_CORES-1:0]    core_re,
    input  logic [N_CORES*64-1:0] core_din,
    input  logic [N_CORES-1:0]    core_we,
    input  logic [N_CORES*32-1:0] core_nonce,
    input  logic                  cmp_re,
    output logic [63:0]           cmp_dout,
    output logic                  cmp_we,
    output logic [31:0]           nonce_out,
    output logic                  nonce_valid,
    output logic [2:0]            grant_id,
    output logic                  busy,
    output logic [31:0]           hashes_routed
);
    localparam int CW = $clog2(WORDS_PER_HASH + 1);

    typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;
    state_t state, state_nxt;

    logic [2:0]    rr_ptr;
    logic [2:0]    arb_idx;
    logic          arb_hit;
    logic [3:0]    scan_idx;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] rd_cnt;
    logic          rd_ok;
    logic          word_in;
    logic          last_word;
    logic          sel_we;
    logic [63:0]   sel_din;
    logic [31:0]   sel_nonce;
    logic [2:0]    rr_next;

    // Cyclic priority scan: lowest offset from rr_ptr wins, so iterate offsets high to low.
    always_comb begin
        arb_hit  = 1'b0;
        arb_idx  = rr_ptr;
        scan_idx = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr} + 4'(k);
            if (scan_idx >= 4'(N_CORES))
                scan_idx = scan_idx - 4'(N_CORES);
            for (int i = 0; i < N_CORES; i++) begin
                if (req[i] && scan_idx == 4'(i)) begin
                    arb_hit = 1'b1;
                    arb_idx = 3'(i);
                end
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_din   = '0;
        sel_nonce = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (grant_id == 3'(i)) begin
                sel_we    = core_we[i];
                sel_din   = core_din[i*64 +: 64];
                sel_nonce = core_nonce[i*32 +: 32];
            end
        end
    end

    // Reads stop once a whole hash has been requested so the next hash stays in the core FIFO.
    assign rd_ok     = (state == XFER) && !stop && cmp_re && (rd_cnt != CW'(WORDS_PER_HASH));
    assign word_in   = (state == XFER) && !stop && sel_we;
    assign last_word = word_in && (word_cnt == CW'(WORDS_PER_HASH - 1));
    assign rr_next   = (grant_id == 3'(N_CORES - 1)) ? 3'd0 : grant_id + 3'd1;
    assign busy      = (state == XFER);

    always_comb begin
        core_re = '0;
        for (int i = 0; i < N_CORES; i++)
            core_re[i] = rd_ok && (grant_id == 3'(i));
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !stop) state_nxt = ARB;
            ARB:     if (stop) state_nxt = IDLE;
                     else if (arb_hit) state_nxt = XFER;
            XFER:    if (stop) state_nxt = IDLE;
                     else if (last_word) state_nxt = ARB;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            word_cnt    <= '0;
            rd_cnt      <= '0;
            cmp_dout    <= '0;
            cmp_we      <= 1'b0;
            nonce_out   <= '0;
            nonce_valid <= 1'b0;
        end else begin
            cmp_we      <= word_in;
            nonce_valid <= last_word;
            if (word_in)
                cmp_dout <= sel_din;
            if (state == ARB && !stop && arb_hit) begin
                grant_id <= arb_idx;
                word_cnt <= '0;
                rd_cnt   <= '0;
            end else if (stop || last_word) begin
                word_cnt <= '0;
                rd_cnt   <= '0;
            end else begin
                if (word_in)
                    word_cnt <= word_cnt + 1'b1;
                if (rd_ok)
                    rd_cnt <= rd_cnt + 1'b1;
            end
            if (last_word) begin
                nonce_out <= sel_nonce;
                rr_ptr    <= rr_next;
            end
        end
    end

`ifdef CMP_SCHED_STATS_EN
    logic [31:0] stat_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            stat_cnt <= '0;
        else if (state == IDLE && start && !stop)
            stat_cnt <= '0;
        else if (last_word)
            stat_cnt <= stat_cnt + 32'd1;
    end

    assign hashes_routed = stat_cnt;
`else
    assign hashes_routed = '0;
`endif

endmodule

// File: tb/tb_compare_sched.sv
// Bench for compare_sched: behavioural core FIFOs, a word/nonce scoreboard and a grant-order table.
module tb_compare_sched;
    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    logic [3:0]   req;
    logic [3:0]   core_re;
    logic [255:0] core_din;
    logic [3:0]   core_we;
    logic [127:0] core_nonce;
    logic         cmp_re;
    logic [63:0]  cmp_dout;
    logic         cmp_we;
    logic [31:0]  nonce_out;
    logic         nonce_valid;
    logic [2:0]   grant_id;
    logic         busy;
    logic [31:0]  hashes_routed;

    int total = 0;
    int bad   = 0;
    int n_nv  = 0;

    logic [63:0] exp_w[$];
    logic [31:0] exp_n[$];
    int          exp_h[4];
    int          rdcnt[4];
    logic [3:0]  pend;
    logic [3:0]  spur_we;
    logic [3:0]  flush;

    typedef struct {
        logic [3:0] rq;
        int         g;
    } vec_t;
    vec_t tbl[10];

    compare_sched dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .req(req),
        .core_re(core_re), .core_din(core_din), .core_we(core_we),
        .core_nonce(core_nonce), .cmp_re(cmp_re), .cmp_dout(cmp_dout),
        .cmp_we(cmp_we), .nonce_out(nonce_out), .nonce_valid(nonce_valid),
        .grant_id(grant_id), .busy(busy), .hashes_routed(hashes_routed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    function automatic logic [63:0] mk_word(input int i, input int r);
        logic [3:0] top;
        top = 4'hA + 4'(r % 4);
        return {top, 12'h000, 8'(i), 8'(r / 4), 32'h0F0F_0000 | 32'(r)};
    endfunction

    function automatic logic [31:0] nonce_of(input int i, input int h);
        if (i == 2 && h == 0)
            return 32'h1234_5678;
        return 32'h6000_0000 + 32'(i << 16) + 32'(h);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_hash(input int g, input int nw, input bit with_n);
        for (int w = 0; w < nw; w++)
            exp_w.push_back(mk_word(g, 4 * exp_h[g] + w));
        if (with_n)
            exp_n.push_back(nonce_of(g, exp_h[g]));
        exp_h[g]++;
    endtask

    // Behavioural core FIFOs: answer a read one cycle later, present head-hash nonce.
    initial begin
        core_we    = '0;
        core_din   = '0;
        core_nonce = '0;
        pend       = '0;
        for (int i = 0; i < 4; i++) rdcnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (flush[i]) rdcnt[i] = (rdcnt[i] + 3) / 4 * 4;
                core_we[i] = pend[i] | spur_we[i];
                if (pend[i]) begin
                    core_din[i*64 +: 64] = mk_word(i, rdcnt[i]);
                    rdcnt[i]++;
                end else if (spur_we[i]) begin
                    core_din[i*64 +: 64] = 64'hDEAD_BEEF_DEAD_BEEF;
                end
                core_nonce[i*32 +: 32] = nonce_of(i, (rdcnt[i] == 0) ? 0 : (rdcnt[i] - 1) / 4);
            end
            #3;
            pend = core_re;
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [63:0] ew;
        logic [31:0] en;
        forever begin
            @(posedge clk);
            #3;
            if (cmp_we) begin
                if (exp_w.size() == 0) begin
                    check("cmp_we_unexpected", 64'(cmp_we), 64'd0);
                end else begin
                    ew = exp_w.pop_front();
                    check("cmp_dout", cmp_dout, ew);
                end
            end
            if (nonce_valid) begin
                n_nv++;
                check("nv_with_cmp_we", 64'(cmp_we), 64'd1);
                if (exp_n.size() == 0) begin
                    check("nonce_valid_unexpected", 64'(nonce_valid), 64'd0);
                end else begin
                    en = exp_n.pop_front();
                    check("nonce_out", 64'(nonce_out), 64'(en));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmp_dout"}, cmp_dout, 64'd0);
        check({tag, "_cmp_we"}, 64'(cmp_we), 64'd0);
        check({tag, "_nonce_out"}, 64'(nonce_out), 64'd0);
        check({tag, "_nonce_valid"}, 64'(nonce_valid), 64'd0);
        check({tag, "_grant_id"}, 64'(grant_id), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_core_re"}, 64'(core_re), 64'd0);
        check({tag, "_hashes_routed"}, 64'(hashes_routed), 64'd0);
    endtask

    task automatic run_hash(input logic [3:0] rq, input int g, input bit spur, input string nm);
        int cyc, nwe, first, last;
        bit got, stray;
        req = rq;
        push_hash(g, 4, 1'b1);
        cyc = 0;
        while (!busy && cyc < 20) begin
            tick();
            cyc++;
        end
        check({nm, "_busy"}, 64'(busy), 64'd1);
        check({nm, "_grant"}, 64'(grant_id), 64'(g));
        got = 1'b0; stray = 1'b0; nwe = 0; first = 0; last = 0; cyc = 0;
        while (!got && cyc < 40) begin
            if ((core_re & ~(4'b0001 << g)) != 4'b0000) stray = 1'b1;
            tick();
            cyc++;
            spur_we = 4'b0000;
            if (cmp_we) begin
                nwe++;
                if (nwe == 1) begin
                    first = cyc;
                    if (spur) spur_we = 4'b1000;
                end
            end
            if (nonce_valid) begin
                got  = 1'b1;
                last = cyc;
            end
        end
        check({nm, "_nonce_seen"}, 64'(got), 64'd1);
        check({nm, "_word_count"}, 64'(nwe), 64'd4);
        check({nm, "_no_gaps"}, 64'(last - first), 64'd3);
        check({nm, "_core_re_onehot"}, 64'(stray), 64'd0);
    endtask

    initial begin
        int cyc, cnt, nv_base;
        rst = 1'b1; start = 1'b0; stop = 1'b0; req = '0; cmp_re = 1'b1;
        spur_we = '0; flush = '0;
        for (int i = 0; i < 4; i++) exp_h[i] = 0;

        tbl[0] = '{4'b1111, 0};
        tbl[1] = '{4'b1111, 1};
        tbl[2] = '{4'b1111, 2};
        tbl[3] = '{4'b1111, 3};
        tbl[4] = '{4'b1111, 0};
        tbl[5] = '{4'b0100, 2};
        tbl[6] = '{4'b1001, 3};
        tbl[7] = '{4'b0011, 0};
        tbl[8] = '{4'b1010, 1};
        tbl[9] = '{4'b0001, 0};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        // IDLE must ignore requests until start.
        req = 4'b1111;
        repeat (3) tick();
        check("idle_no_start_busy", 64'(busy), 64'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++)
            run_hash(tbl[k].rq, tbl[k].g, 1'b0, $sformatf("tbl%0d", k));

`ifndef CMP_SCHED_STATS_EN
        check("stats_disabled_zero", 64'(hashes_routed), 64'd0);
`endif

        // Abort grant 1 after two words; rr_ptr must still point at core 1.
        req = 4'b1111;
        push_hash(1, 2, 1'b0);
        cyc = 0;
        while (!busy && cyc < 20) begin
            tick();
            cyc++;
        end
        check("stop_grant", 64'(grant_id), 64'd1);
        cnt = 0; cyc = 0;
        while (cnt < 2 && cyc < 20) begin
            tick();
            cyc++;
            if (cmp_we) cnt++;
        end
        check("stop_two_words", 64'(cnt), 64'd2);
        nv_base = n_nv;
        stop = 1'b1;
        #1;
        check("stop_core_re_now", 64'(core_re), 64'd0);
        tick();
        check("stop_busy", 64'(busy), 64'd0);
        stop = 1'b0;
        flush[1] = 1'b1;
        tick();
        flush = '0;
        repeat (4) tick();
        check("stop_no_nonce", 64'(n_nv - nv_base), 64'd0);
        check("stop_idle_core_re", 64'(core_re), 64'd0);

        // Simultaneous start and stop: stop wins.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (3) tick();
        check("start_stop_busy", 64'(busy), 64'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        run_hash(4'b1111, 1, 1'b0, "resume");

        // Stray core_we[3] while core 0 streams.
        run_hash(4'b0001, 0, 1'b1, "spur");

        // Reset on the third word of grant 2.
        req = 4'b0100;
        push_hash(2, 3, 1'b0);
        cyc = 0;
        while (!busy && cyc < 20) begin
            tick();
            cyc++;
        end
        check("rst_grant", 64'(grant_id), 64'd2);
        cnt = 0; cyc = 0;
        while (cnt < 3 && cyc < 20) begin
            tick();
            cyc++;
            if (cmp_we) cnt++;
        end
        check("rst_three_words", 64'(cnt), 64'd3);
        nv_base = n_nv;
        rst = 1'b1;
        tick();
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        flush[2] = 1'b1;
        tick();
        flush = '0;
        repeat (4) tick();
        check("rst_stays_idle", 64'(busy), 64'd0);
        check("rst_no_nonce", 64'(n_nv - nv_base), 64'd0);

        // rr_ptr back at 0 after reset: core 0 beats core 2.
        start = 1'b1;
        tick();
        start = 1'b0;
        run_hash(4'b0101, 0, 1'b0, "post_rst");

`ifdef CMP_SCHED_STATS_EN
        check("stats_count", 64'(hashes_routed), 64'd1);
        req = 4'b0000;
        tick();
        dut.stat_cnt = 32'hFFFF_FFFF;
        run_hash(4'b0010, 1, 1'b0, "stats_wrap");
        tick();
        check("stats_wrap_zero", 64'(hashes_routed), 64'd0);
`else
        check("stats_disabled_end", 64'(hashes_routed), 64'd0);
`endif

        req = 4'b0000;
        repeat (4) tick();
        check("words_left", 64'(exp_w.size()), 64'd0);
        check("nonces_left", 64'(exp_n.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/compare_sched.md
COMPARE_SCHED -- requirements
Module: compare_sched

Interface
REQ-001 Parameter N_CORES, default 4, number of heavy-hash cores sharing one comparator (2..8).
REQ-002 Parameter WORDS_PER_HASH, default 4, 64-bit words per 256-bit hash.
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  pulse; enables scheduling.
REQ-006 stop  input  1  level; aborts any transfer and disables scheduling.
REQ-007 req  input  N_CORES  core i has at least one complete hash buffered.
REQ-008 core_re  output  N_CORES  read enable to core i hash FIFO; one-hot or zero.
REQ-009 core_din  input  N_CORES*64  hash word from core i, slice [64*i+63:64*i].
REQ-010 core_we  input  N_CORES  core_din slice i valid; 1 cycle after core_re[i].
REQ-011 core_nonce  input  N_CORES*32  nonce of core i's head hash.
REQ-012 cmp_re  input  1  comparator ready for next word.
REQ-013 cmp_dout  output  64  hash word to comparator, most-significant word first.
REQ-014 cmp_we  output  1  cmp_dout valid, one-cycle pulse per word.
REQ-015 nonce_out  output  32  nonce of the most recently completed hash.
REQ-016 nonce_valid  output  1  one-cycle pulse when nonce_out updates.
REQ-017 grant_id  output  3  index of the granted core; holds last value when idle.
REQ-018 busy  output  1  high in XFER.
REQ-019 hashes_routed  output  32  completed hash transfers (see Configuration).

Function
REQ-020 States: IDLE, ARB, XFER; IDLE->ARB on start with stop low.
REQ-021 ARB: when any req bit is high, grant the first requester at or after rr_ptr (cyclic), set grant_id, go XFER next cycle; with no req, stay in ARB.
REQ-022 XFER: core_re[grant_id] = cmp_re (combinational); all other core_re bits low; core_re low in IDLE/ARB.
REQ-023 On core_we[grant_id], register core_din slice into cmp_dout and pulse cmp_we the following cycle; increment word count.
REQ-024 core_we of non-granted cores is ignored.
REQ-025 On the WORDS_PER_HASH-th word: latch core_nonce[grant_id] into nonce_out, pulse nonce_valid the same cycle as the final cmp_we, set rr_ptr = grant_id+1 modulo N_CORES, return to ARB.
REQ-026 Grant is held for the full hash; req deasserting mid-XFER is ignored.
REQ-027 stop high in ARB or XFER: next state IDLE, word count cleared, no nonce_valid, partial words already sent are not retracted; core_re low from the cycle stop is seen.
REQ-028 start and stop simultaneous: stop wins.
REQ-029 Latency core_we to cmp_we: exactly 1 cycle; zero-bubble streaming when cmp_re held high.

Reset
REQ-030 On rst: state IDLE, rr_ptr 0, grant_id 0, word count 0, cmp_dout 0, cmp_we 0, nonce_out 0, nonce_valid 0, busy 0, hashes_routed 0.
REQ-031 rst mid-XFER takes effect next edge; no further cmp_we or nonce_valid.

Configuration
REQ-032 Macro CMP_SCHED_STATS_EN: when defined, hashes_routed increments by 1 with each nonce_valid, wraps 0xFFFFFFFF->0, cleared on rst and on IDLE->ARB.
REQ-033 Without CMP_SCHED_STATS_EN, hashes_routed is constant 0 and no counter is synthesized.

Verification
REQ-034 req=4'b1111, cmp_re=1 continuously -> grants 0,1,2,3,0 in order; 4 cmp_we per grant, no gaps.
REQ-035 Core 2 words 0xA..,0xB..,0xC..,0xD.., nonce 0x1234_5678 -> cmp_dout same order, nonce_valid with nonce_out=0x12345678 on 4th cmp_we.
REQ-036 stop after 2nd word of grant 1 -> IDLE, core_re=0, no nonce_valid; start again -> grant 1 resumes from rr_ptr.
REQ-037 core_we[3] pulsed while core 0 granted -> cmp_dout unaffected, word count unchanged.
REQ-038 STATS_EN, counter preloaded 0xFFFFFFFF, one hash completes -> hashes_routed=0; without macro -> always 0.
REQ-039 rst asserted on 3rd word -> next cycle all outputs at reset values, state IDLE.
